seq_cmp_unit: RTL and testbench

- Parametrised, multi-cycle magnitude/equality comparator for the branch and set-less-than paths.
- Compares CHUNK bits per cycle, MSB chunk first, and terminates early at the first differing chunk.
- Supports six compare modes, uses valid/ready handshakes on both sides, and has a flush input for pipeline cancellation.
- Sits between the ID/EX operand latch and branch-resolve / writeback; the narrow CHUNK keeps the carry chain off the critical path.

---
 rtl/seq_cmp_unit.sv | 163 ++++++++++++++++
 tb/tb_seq_cmp_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_cmp_unit.sv
// Multi-cycle magnitude/equality comparator: walks CHUNK bits per cycle from the
// MSB end and stops at the first differing chunk; valid/ready on both sides.
module seq_cmp_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  localparam int unsigned NCH = WIDTH / CHUNK,
  localparam int unsigned CW  = $clog2(NCH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res,
  output logic             lt,
  output logic             eq,
  output logic [CW-1:0]    cycles
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_NE  = 3'd1;
  localparam logic [2:0] OP_LT  = 3'd2;
  localparam logic [2:0] OP_GE  = 3'd3;
  localparam logic [2:0] OP_LTU = 3'd4;
  localparam logic [2:0] OP_GEU = 3'd5;

  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CW-1:0]    LAST_CYC  = CW'(NCH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             lt_q, lt_d, eq_q, eq_d, res_q, res_d;

  logic [CHUNK-1:0] a_top, b_top;
  logic [WIDTH-1:0] a_shl, b_shl;
  logic             src_signed;

  // Operands are shifted left each RUN cycle so the chunk under test is always the top one.
  assign a_top = a_q[WIDTH-1 -: CHUNK];
  assign b_top = b_q[WIDTH-1 -: CHUNK];

  generate
    if (NCH > 1) begin : g_shift
      assign a_shl = {a_q[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
      assign b_shl = {b_q[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
    end else begin : g_noshift
      assign a_shl = a_q;
      assign b_shl = b_q;
    end
  endgenerate

  assign src_signed = (op == OP_LT) || (op == OP_GE);

  function automatic logic op_result(input logic [2:0] o, input logic l, input logic e);
    logic r;
    r = 1'b0;
    case (o)
      OP_EQ:          r = e;
      OP_NE:          r = ~e;
      OP_LT, OP_LTU:  r = l;
      OP_GE, OP_GEU:  r = ~l;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state and result computation; flush overrides everything.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cyc_d   = cyc_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    res_d   = res_q;
    if (flush) begin
      state_d = IDLE;
      cyc_d   = '0;
      lt_d    = 1'b0;
      eq_d    = 1'b0;
      res_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d = RUN;
            // Flipping the sign bit makes the unsigned walk produce signed order.
            a_d     = src_signed ? (src1 ^ SIGN_MASK) : src1;
            b_d     = src_signed ? (src2 ^ SIGN_MASK) : src2;
            op_d    = op;
            cyc_d   = '0;
            lt_d    = 1'b0;
            eq_d    = 1'b0;
            res_d   = 1'b0;
          end
        end
        RUN: begin
          cyc_d = cyc_q + CW'(1);
          if (a_top != b_top) begin
            lt_d    = (a_top < b_top);
            eq_d    = 1'b0;
            res_d   = op_result(op_q, a_top < b_top, 1'b0);
            state_d = DONE;
          end else if (cyc_q == LAST_CYC) begin
            lt_d    = 1'b0;
            eq_d    = 1'b1;
            res_d   = op_result(op_q, 1'b0, 1'b1);
            state_d = DONE;
          end else begin
            a_d = a_shl;
            b_d = b_shl;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cyc_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cyc_q   <= cyc_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign cycles    = cyc_q;

endmodule

// File: tb/tb_seq_cmp_unit.sv
// Scoreboard bench for seq_cmp_unit at WIDTH=64, CHUNK=16: driver pushes model
// results on accept, monitor pops and compares on each presented result.
module tb_seq_cmp_unit;

  localparam int W   = 64;
  localparam int C   = 16;
  localparam int NCH = W / C;
  localparam int CW  = $clog2(NCH + 1);

  typedef struct {
    logic res;
    logic lt;
    logic eq;
    int   k;
    int   acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  src1 = '0;
  logic [W-1:0]  src2 = '0;
  logic [2:0]    op = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          res, lt, eq;
  logic [CW-1:0] cycles;

  int   vec = 0;
  int   mis = 0;
  int   cyc_cnt = 0;
  bit   seen = 1'b0;
  exp_t sb[$];

  seq_cmp_unit #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .lt(lt), .eq(eq), .cycles(cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned comparison; latency from the highest differing bit.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    logic [W-1:0] x;
    int p;
    m.eq = (a == b);
    if (o == 3'd2 || o == 3'd3) m.lt = ($signed(a) < $signed(b));
    else                        m.lt = (a < b);
    case (o)
      3'd0: m.res = m.eq;
      3'd1: m.res = !m.eq;
      3'd2, 3'd4: m.res = m.lt;
      3'd3, 3'd5: m.res = !m.lt;
      default: m.res = 1'b0;
    endcase
    x = a ^ b;
    p = -1;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] && p < 0) p = i;
    end
    m.k = (p < 0) ? NCH : ((W - 1 - p) / C + 1);
    m.acc = 0;
    return m;
  endfunction

  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit do_flush);
    exp_t e;
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    src1 = a;
    src2 = b;
    guard = 0;
    while (!in_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        mis++;
        vec++;
        $display("FAIL accept_timeout: in_ready stuck at 0");
        in_valid = 1'b0;
        return;
      end
    end
    e = model(o, a, b);
    e.acc = cyc_cnt + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (do_flush) begin
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      void'(sb.pop_back());
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      chk("flush_in_ready", 64'(in_ready), 64'(1));
      chk("flush_res", 64'(res), 64'(0));
    end
  endtask

  // Monitor: compares every cycle a result is presented, so stalls also check stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && out_valid) begin
        if (sb.size() == 0) begin
          vec++;
          mis++;
          $display("FAIL spurious_result: out_valid=1 expected none");
          out_ready = 1'b1;
        end else begin
          e = sb[0];
          chk("res", 64'(res), 64'(e.res));
          chk("lt", 64'(lt), 64'(e.lt));
          chk("eq", 64'(eq), 64'(e.eq));
          chk("cycles", 64'(cycles), 64'(e.k));
          chk("in_ready_in_done", 64'(in_ready), 64'(0));
          if (!seen) begin
            seen = 1'b1;
            chk("latency", 64'(cyc_cnt - e.acc), 64'(e.k));
          end
          out_ready = ($urandom_range(0, 2) == 0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end else begin
        out_ready = $urandom_range(0, 1) != 0;
      end
    end
  end

  initial begin
    logic [W-1:0] a, b, mask;
    logic [2:0] o;
    int j, guard;

    #13;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_res", 64'(res), 64'(0));
    chk("rst_cycles", 64'(cycles), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_lt_eq", 64'({lt, eq}), 64'(0));

    // Flush must win over a simultaneous accept.
    in_valid = 1'b1;
    op = 3'd0;
    flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_vs_accept", 64'(in_ready), 64'(1));

    send(3'd4, 64'h1, {W{1'b1}}, 1'b0);
    send(3'd2, {W{1'b1}}, 64'h1, 1'b0);
    send(3'd4, {W{1'b1}}, 64'h1, 1'b0);
    send(3'd0, 64'h1234_5678_9abc_def0, 64'h1234_5678_9abc_def0, 1'b0);
    send(3'd5, 64'h1234_5678_9abc_def0, 64'h1234_5678_9abc_def0, 1'b0);
    send(3'd1, 64'h1234_5678_9abc_0000, 64'h1234_5678_9abc_0001, 1'b0);
    send(3'd3, 64'h8000_0000_0000_0000, 64'h7fff_ffff_ffff_ffff, 1'b0);
    send(3'd3, 64'h8000_0000_0000_0000, 64'h7fff_ffff_ffff_ffff, 1'b1);
    send(3'd6, 64'h55, 64'h55, 1'b0);
    send(3'd7, 64'h1, 64'h2, 1'b0);

    for (int n = 0; n < 200; n++) begin
      o = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      mask = {$urandom, $urandom};
      j = $urandom_range(0, NCH);
      mask = (j == NCH) ? '0 : (mask >> (j * C));
      b = a ^ mask;
      if ($urandom_range(0, 1) != 0) begin
        {a, b} = {b, a};
      end
      send(o, a, b, ($urandom_range(0, 9) == 0));
    end

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));

    // Async reset while a compare is running.
    send(3'd0, 64'hdead_beef_0000_1111, 64'hdead_beef_0000_1111, 1'b0);
    #3 resetn = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_flags", 64'({res, lt, eq}), 64'(0));
    chk("arst_cycles", 64'(cycles), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    void'(sb.pop_back());
    @(negedge clk);
    resetn = 1'b1;
    repeat (NCH + 2) @(negedge clk);
    chk("post_arst_idle", 64'({in_ready, out_valid}), 64'(2'b10));

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
